yblock_cfg_loader: RTL and testbench

Configuration sequencer that sits directly upstream of a yellow-cell block and drives its control port.
- Clears the array, then accepts column-parallel configuration words over a valid/ready handshake.
- Presents each word on cbitin and issues one clean confclk strobe per word, with programmable setup and pulse width.
- Counts strobes until the whole vertical configuration chain (CHAINLEN bits per column) is loaded, then releases the array for operation.

---
 rtl/yblock_cfg_loader.sv | 182 ++++++++++++++++++
 tb/tb_yblock_cfg_loader.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/yblock_cfg_loader.sv
// yblock_cfg_loader: clears a yellow-cell block, then shifts column-parallel configuration
// words into its vertical chains, one confclk strobe per word, and releases the array when
// CHAINLEN strobes have been issued.
// Ports: clk/reset (async, active-high); start; cfg_valid/cfg_ready/cfg_data word handshake;
// blk_reset/confclk/cbitin drive the block; cbitout is the block's chain output;
// busy/done status; rb_data/rb_valid readback.
// Optional feature macro: CONF_READBACK_EN (capture cbitout in every HOLD cycle).
// All outputs come straight from flops; next values are decoded from the next state.
module yblock_cfg_loader #(
  parameter int BLOCKWIDTH = 8,
  parameter int CHAINLEN   = 16,
  parameter int CLRCYCLES  = 4,
  parameter int SETUPCYC   = 2,
  parameter int PULSECYC   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [BLOCKWIDTH-1:0] cfg_data,
  output logic                  blk_reset,
  output logic                  confclk,
  output logic [BLOCKWIDTH-1:0] cbitin,
  input  logic [BLOCKWIDTH-1:0] cbitout,
  output logic                  busy,
  output logic                  done,
  output logic [BLOCKWIDTH-1:0] rb_data,
  output logic                  rb_valid
);

  // One phase counter serves CLEAR, SETUP and STROBE, so size it for the longest.
  localparam int MAXPH = (CLRCYCLES > SETUPCYC) ?
                         ((CLRCYCLES > PULSECYC) ? CLRCYCLES : PULSECYC) :
                         ((SETUPCYC > PULSECYC) ? SETUPCYC : PULSECYC);
  localparam int PW = $clog2(MAXPH + 1);
  localparam int CW = $clog2(CHAINLEN + 1);

  localparam logic [PW-1:0] CLR_LAST = PW'(CLRCYCLES - 1);
  localparam logic [PW-1:0] SU_LAST  = PW'(SETUPCYC - 1);
  localparam logic [PW-1:0] PU_LAST  = PW'(PULSECYC - 1);
  localparam logic [CW-1:0] WRD_LAST = CW'(CHAINLEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_SETUP, S_STROBE, S_HOLD, S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [PW-1:0]           ph_q, ph_d;
  logic [CW-1:0]           word_q, word_d;
  logic [BLOCKWIDTH-1:0]   cbitin_q, cbitin_d;
  logic                    blk_reset_q, blk_reset_d;
  logic                    confclk_q, confclk_d;
  logic                    cfg_ready_q, cfg_ready_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    word_d   = word_q;
    cbitin_d = cbitin_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        // start is only looked at here, so a request mid-sequence is dropped.
        if (start) begin
          state_d = S_CLEAR;
          ph_d    = '0;
        end
      end
      S_CLEAR: begin
        word_d = '0;
        if (ph_q == CLR_LAST) begin
          state_d = S_LOAD;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      S_LOAD: begin
        if (cfg_valid && cfg_ready_q) begin
          state_d  = S_SETUP;
          ph_d     = '0;
          cbitin_d = cfg_data;
        end
      end
      S_SETUP: begin
        if (ph_q == SU_LAST) begin
          state_d = S_STROBE;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      S_STROBE: begin
        if (ph_q == PU_LAST) begin
          state_d = S_HOLD;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      S_HOLD: begin
        // Low cycle after the pulse keeps cbitin stable past the falling edge.
        if (word_q == WRD_LAST) begin
          word_d  = '0;
          state_d = S_DONE;
        end else begin
          word_d  = word_q + 1'b1;
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase

    blk_reset_d = (state_d == S_IDLE) || (state_d == S_CLEAR);
    confclk_d   = (state_d == S_STROBE);
    cfg_ready_d = (state_d == S_LOAD);
    busy_d      = (state_d == S_CLEAR) || (state_d == S_LOAD) || (state_d == S_SETUP) ||
                  (state_d == S_STROBE) || (state_d == S_HOLD);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ph_q        <= '0;
      word_q      <= '0;
      cbitin_q    <= '0;
      blk_reset_q <= 1'b1;
      confclk_q   <= 1'b0;
      cfg_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      word_q      <= word_d;
      cbitin_q    <= cbitin_d;
      blk_reset_q <= blk_reset_d;
      confclk_q   <= confclk_d;
      cfg_ready_q <= cfg_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign blk_reset = blk_reset_q;
  assign confclk   = confclk_q;
  assign cbitin    = cbitin_q;
  assign cfg_ready = cfg_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef CONF_READBACK_EN
  // Sampled on entry to HOLD: the block shifted on the preceding rising confclk, so
  // cbitout already shows the bit pushed out of each column by this word.
  logic [BLOCKWIDTH-1:0] rb_data_q;
  logic                  rb_valid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      rb_valid_q <= (state_d == S_HOLD);
      if (state_d == S_HOLD) begin
        rb_data_q <= cbitout;
      end
    end
  end

  assign rb_data  = rb_data_q;
  assign rb_valid = rb_valid_q;
`else
  logic unused_cbitout;
  assign unused_cbitout = ^cbitout;
  assign rb_data  = '0;
  assign rb_valid = 1'b0;
`endif

endmodule

// File: tb/tb_yblock_cfg_loader.sv
`timescale 1ns/1ps
module tb_yblock_cfg_loader;
  localparam int W   = 8;
  localparam int CL  = 4;
  localparam int CLR = 4;
  localparam int SU  = 1;
  localparam int PU  = 2;
`ifdef CONF_READBACK_EN
  localparam int RBN = CL;
`else
  localparam int RBN = 0;
`endif

  logic clk = 1'b0;
  logic reset, start, cfg_valid;
  logic [W-1:0] cfg_data, cbitout;
  logic cfg_ready, blk_reset, confclk, busy, done, rb_valid;
  logic [W-1:0] cbitin, rb_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  yblock_cfg_loader #(.BLOCKWIDTH(W), .CHAINLEN(CL), .CLRCYCLES(CLR),
                      .SETUPCYC(SU), .PULSECYC(PU)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_data(cfg_data), .blk_reset(blk_reset),
    .confclk(confclk), .cbitin(cbitin), .cbitout(cbitout), .busy(busy),
    .done(done), .rb_data(rb_data), .rb_valid(rb_valid));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model of the driven block: CL-deep chain per column, shifted on
  // rising confclk; cbitout registers the bit that falls off the end.
  logic [W-1:0] chain [CL];
  always @(posedge confclk) begin
    cbitout <= chain[CL-1];
    for (int i = CL-1; i > 0; i--) chain[i] <= chain[i-1];
    chain[0] <= cbitin;
  end

  // Event monitor, sampled on the falling edge.
  int rise_c[$], fall_c[$], rb_c[$];
  logic [W-1:0] rise_d[$], rb_d[$];
  int brst_fall, done_c;
  logic cc_p = 1'b0, br_p = 1'b1, dn_p = 1'b0;

  always @(negedge clk) begin
    if (confclk === 1'b1 && !cc_p) begin rise_c.push_back(cyc); rise_d.push_back(cbitin); end
    if (confclk === 1'b0 && cc_p) fall_c.push_back(cyc);
    if (blk_reset === 1'b0 && br_p && brst_fall < 0) brst_fall = cyc;
    if (done === 1'b1 && !dn_p && done_c < 0) done_c = cyc;
    if (rb_valid === 1'b1) begin rb_c.push_back(cyc); rb_d.push_back(rb_data); end
    cc_p = (confclk === 1'b1);
    br_p = (blk_reset === 1'b1);
    dn_p = (done === 1'b1);
    total++;
    assert ((confclk & (blk_reset | cfg_ready)) === 1'b0)
      else begin bad++; $error("FAIL safety: confclk=%b blk_reset=%b cfg_ready=%b required confclk low", confclk, blk_reset, cfg_ready); end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
      else begin bad++; $error("FAIL %s: observed %0h expected %0h", tag, obs, exp); end
  endtask

  logic inj_en = 1'b0, inj_done = 1'b0;

  // Advance to 1ns after the next rising edge; optionally fire a stray start while confclk is high.
  task automatic tick();
    @(posedge clk); #1;
    start = 1'b0;
    if (inj_en && !inj_done && confclk === 1'b1) begin start = 1'b1; inj_done = 1'b1; end
  endtask

  task automatic clear_mon();
    rise_c.delete(); fall_c.delete(); rb_c.delete(); rise_d.delete(); rb_d.delete();
    brst_fall = -1; done_c = -1;
  endtask

  logic [W-1:0] words [CL];
  logic [W-1:0] prevw [CL];
  int gaps [CL];
  int acc_exp [CL];
  int acc_obs [CL];

  // Full clear-and-load; expected timing derived from the word period 1+SU+PU+1.
  task automatic do_load(input bit chk_rb_prev);
    int s, n, rdy, vst;
    clear_mon();
    start = 1'b1; s = cyc;
    tick();
    chk("start_busy", busy, 1); chk("start_done_clr", done, 0); chk("start_blkrst", blk_reset, 1);
    for (int i = 0; i < CL; i++) begin
      rdy = (i == 0) ? s + 1 + CLR : acc_exp[i-1] + 2 + SU + PU;
      vst = (i == 0) ? s + 1 + gaps[0] : acc_exp[i-1] + 1 + gaps[i];
      acc_exp[i] = (rdy > vst) ? rdy : vst;
    end
    for (int i = 0; i < CL; i++) begin
      cfg_valid = 1'b0;
      for (int g = 0; g < gaps[i]; g++) tick();
      cfg_valid = 1'b1; cfg_data = words[i];
      n = 0;
      while (cfg_ready !== 1'b1 && n < 200) begin tick(); n++; end
      chk("ready_seen", cfg_ready, 1);
      acc_obs[i] = cyc;
      tick();
    end
    cfg_valid = 1'b0; cfg_data = '0;
    n = 0;
    while (done !== 1'b1 && n < 200) begin tick(); n++; end
    chk("done_reached", done, 1);
    repeat (3) tick();
    chk("blkrst_fall", brst_fall, s + 1 + CLR);
    chk("pulse_count", rise_c.size(), CL);
    chk("fall_count", fall_c.size(), CL);
    for (int i = 0; i < CL; i++) begin
      chk("accept_cyc", acc_obs[i], acc_exp[i]);
      chk("rise_cyc", (i < rise_c.size()) ? rise_c[i] : -1, acc_exp[i] + 1 + SU);
      chk("rise_data", (i < rise_d.size()) ? rise_d[i] : 'x, words[i]);
      chk("fall_cyc", (i < fall_c.size()) ? fall_c[i] : -1, acc_exp[i] + 1 + SU + PU);
    end
    chk("done_cyc", done_c, acc_exp[CL-1] + 2 + SU + PU);
    chk("final_cbitin", cbitin, words[CL-1]);
    chk("final_busy", busy, 0);
    chk("final_blkrst", blk_reset, 0);
    chk("final_ready", cfg_ready, 0);
    chk("final_confclk", confclk, 0);
    chk("rb_count", rb_c.size(), RBN);
    chk("rb_final_valid", rb_valid, 0);
    if (chk_rb_prev && RBN > 0) begin
      for (int i = 0; i < CL; i++) begin
        chk("rb_data", (i < rb_d.size()) ? rb_d[i] : 'x, prevw[i]);
        chk("rb_cyc", (i < rb_c.size()) ? rb_c[i] : -1, acc_exp[i] + 1 + SU + PU);
      end
    end
  endtask

  initial begin
    int n;
    logic [W-1:0] dir [CL];
    dir[0] = 8'hA5; dir[1] = 8'h3C; dir[2] = 8'hFF; dir[3] = 8'h00;
    for (int i = 0; i < CL; i++) chain[i] = '0;
    cbitout = '0; reset = 1'b1; start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
    brst_fall = -1; done_c = -1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) tick();
    // reset asserted mid-cycle takes effect immediately
    #3 reset = 1'b1;
    #1;
    chk("rst_blkrst", blk_reset, 1); chk("rst_confclk", confclk, 0);
    chk("rst_ready", cfg_ready, 0); chk("rst_done", done, 0); chk("rst_busy", busy, 0);
    chk("rst_cbitin", cbitin, 0); chk("rst_rbvalid", rb_valid, 0); chk("rst_rbdata", rb_data, 0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (6) tick();
    chk("idle_blkrst", blk_reset, 1); chk("idle_busy", busy, 0);
    chk("idle_done", done, 0); chk("idle_ready", cfg_ready, 0); chk("idle_confclk", confclk, 0);

    // Session 1: directed words, valid always high
    for (int i = 0; i < CL; i++) begin words[i] = dir[i]; gaps[i] = 0; end
    do_load(1'b0);
    chk("spec_done_20", done_c - brst_fall, 20);
    for (int i = 0; i < CL; i++) prevw[i] = words[i];

    // Session 2: random words/gaps, 7-cycle valid gap before word 3, stray start during STROBE
    for (int i = 0; i < CL; i++) begin words[i] = W'($urandom); gaps[i] = $urandom_range(0, 8); end
    gaps[2] = 7;
    inj_en = 1'b1; inj_done = 1'b0;
    do_load(1'b1);
    chk("stray_start_fired", inj_done, 1);
    inj_en = 1'b0;

    // Session 3: reset during the second STROBE cycle of word 3
    for (int i = 0; i < CL; i++) words[i] = W'($urandom);
    clear_mon();
    start = 1'b1; tick();
    cfg_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cfg_data = words[i]; n = 0;
      while (cfg_ready !== 1'b1 && n < 100) begin tick(); n++; end
      tick();
    end
    cfg_valid = 1'b0;
    n = 0;
    while (confclk !== 1'b1 && n < 50) begin tick(); n++; end
    tick();
    chk("abort_pre_confclk", confclk, 1);
    chk("abort_pre_rises", rise_c.size(), 3);
    #2 reset = 1'b1;
    #1;
    chk("abort_confclk", confclk, 0); chk("abort_blkrst", blk_reset, 1);
    chk("abort_busy", busy, 0); chk("abort_ready", cfg_ready, 0); chk("abort_done", done, 0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (4) tick();
    chk("abort_idle_busy", busy, 0); chk("abort_idle_done", done, 0);
    chk("abort_idle_confclk", confclk, 0);

    // Session 4: full reload after abort needs all CL words again
    for (int i = 0; i < CL; i++) begin words[i] = W'($urandom); gaps[i] = $urandom_range(0, 6); end
    do_load(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
